// File: rtl/l1_ddr_arbiter.sv
// Shares one cacheline-wide DDR port between the L1 icache (requester 0) and the
// L1 dcache (requester 1). One transaction is in flight at a time. The granted
// request is registered onto the DDR port, and the response is routed back to
// the requester that owns the transaction.
//
// Default arbitration is round-robin on a tie.
// Optional build macro L1ARB_DCACHE_PRIORITY_EN: on a tie the dcache wins. After
// three consecutive dcache-won ties, the next tie goes to the icache.
module l1_ddr_arbiter #(
    parameter int unsigned addr_bits = 32,
    parameter int unsigned line_bits = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addr_bits-1:0] l1i_arb_addr,
    input  logic                 l1i_arb_read,
    input  logic                 l1i_arb_write,
    input  logic [line_bits-1:0] l1i_arb_wdata,
    output logic [line_bits-1:0] arb_l1i_rdata,
    output logic                 arb_l1i_resp,
    input  logic [addr_bits-1:0] l1d_arb_addr,
    input  logic                 l1d_arb_read,
    input  logic                 l1d_arb_write,
    input  logic [line_bits-1:0] l1d_arb_wdata,
    output logic [line_bits-1:0] arb_l1d_rdata,
    output logic                 arb_l1d_resp,
    output logic [addr_bits-1:0] arb_ddr_addr,
    output logic                 arb_ddr_read,
    output logic                 arb_ddr_write,
    output logic [line_bits-1:0] arb_ddr_wdata,
    input  logic [line_bits-1:0] ddr_arb_rdata,
    input  logic                 ddr_arb_resp
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    // Owner of the most recent grant (0 = icache, 1 = dcache); also the current owner.
    logic                 last_grant_q, last_grant_d;
    logic [addr_bits-1:0] addr_q, addr_d;
    logic [line_bits-1:0] wdata_q, wdata_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [line_bits-1:0] i_rdata_q, i_rdata_d;
    logic [line_bits-1:0] d_rdata_q, d_rdata_d;
    logic                 i_resp_q, i_resp_d;
    logic                 d_resp_q, d_resp_d;
`ifdef L1ARB_DCACHE_PRIORITY_EN
    logic [1:0]           starve_q, starve_d;
`endif

    logic pend_i, pend_d, tie, sel;

    assign pend_i = l1i_arb_read | l1i_arb_write;
    assign pend_d = l1d_arb_read | l1d_arb_write;
    assign tie    = pend_i & pend_d;

    // Owner selection among pending requesters.
    always_comb begin
        sel = 1'b0;
        if (pend_d && !pend_i) begin
            sel = 1'b1;
        end else if (tie) begin
`ifdef L1ARB_DCACHE_PRIORITY_EN
            sel = (starve_q != 2'd3);
`else
            sel = ~last_grant_q;
`endif
        end
    end

    // Next-state and registered-output logic for the grant/busy/done sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
`ifdef L1ARB_DCACHE_PRIORITY_EN
        starve_d     = starve_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pend_i || pend_d) begin
                    state_d      = StBusy;
                    last_grant_d = sel;
                    addr_d       = sel ? l1d_arb_addr  : l1i_arb_addr;
                    wdata_d      = sel ? l1d_arb_wdata : l1i_arb_wdata;
                    // Read and write both high is treated as a write.
                    wr_d         = sel ? l1d_arb_write : l1i_arb_write;
                    rd_d         = sel ? (l1d_arb_read & ~l1d_arb_write)
                                       : (l1i_arb_read & ~l1i_arb_write);
`ifdef L1ARB_DCACHE_PRIORITY_EN
                    if (!sel) begin
                        starve_d = 2'd0;
                    end else if (tie) begin
                        starve_d = starve_q + 2'd1;
                    end
`endif
                end
            end
            StBusy: begin
                if (ddr_arb_resp) begin
                    state_d = StDone;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (last_grant_q) begin
                        d_rdata_d = ddr_arb_rdata;
                        d_resp_d  = 1'b1;
                    end else begin
                        i_rdata_d = ddr_arb_rdata;
                        i_resp_d  = 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
`ifdef L1ARB_DCACHE_PRIORITY_EN
            starve_q     <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
`ifdef L1ARB_DCACHE_PRIORITY_EN
            starve_q     <= starve_d;
`endif
        end
    end

    assign arb_ddr_addr  = addr_q;
    assign arb_ddr_wdata = wdata_q;
    assign arb_ddr_read  = rd_q;
    assign arb_ddr_write = wr_q;
    assign arb_l1i_rdata = i_rdata_q;
    assign arb_l1d_rdata = d_rdata_q;
    assign arb_l1i_resp  = i_resp_q;
    assign arb_l1d_resp  = d_resp_q;

endmodule

// File: tb/tb_l1_ddr_arbiter.sv
// Randomized self-checking bench for l1_ddr_arbiter. A transaction-level model
// tracks pending requests, the arbitration rule, and the returned lines.
module tb_l1_ddr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  l1i_arb_addr, l1d_arb_addr, arb_ddr_addr;
    logic         l1i_arb_read, l1i_arb_write, l1d_arb_read, l1d_arb_write;
    logic [255:0] l1i_arb_wdata, l1d_arb_wdata, arb_l1i_rdata, arb_l1d_rdata;
    logic         arb_l1i_resp, arb_l1d_resp, arb_ddr_read, arb_ddr_write;
    logic [255:0] arb_ddr_wdata, ddr_arb_rdata;
    logic         ddr_arb_resp;

    l1_ddr_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .l1i_arb_addr  (l1i_arb_addr),
        .l1i_arb_read  (l1i_arb_read),
        .l1i_arb_write (l1i_arb_write),
        .l1i_arb_wdata (l1i_arb_wdata),
        .arb_l1i_rdata (arb_l1i_rdata),
        .arb_l1i_resp  (arb_l1i_resp),
        .l1d_arb_addr  (l1d_arb_addr),
        .l1d_arb_read  (l1d_arb_read),
        .l1d_arb_write (l1d_arb_write),
        .l1d_arb_wdata (l1d_arb_wdata),
        .arb_l1d_rdata (arb_l1d_rdata),
        .arb_l1d_resp  (arb_l1d_resp),
        .arb_ddr_addr  (arb_ddr_addr),
        .arb_ddr_read  (arb_ddr_read),
        .arb_ddr_write (arb_ddr_write),
        .arb_ddr_wdata (arb_ddr_wdata),
        .ddr_arb_rdata (ddr_arb_rdata),
        .ddr_arb_resp  (ddr_arb_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: per-requester pending transaction and last returned line.
    bit           m_pend [2];
    bit           m_rd   [2];
    bit           m_wr   [2];
    logic [31:0]  m_addr [2];
    logic [255:0] m_wdata[2];
    logic [255:0] m_rdata[2];
    logic [31:0]  m_ddr_addr;
    logic [255:0] m_ddr_wdata;
    int           m_last;
    int           m_starve;
    int           last_owner;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive(input int who);
        if (who == 0) begin
            l1i_arb_read  = m_pend[0] & m_rd[0];
            l1i_arb_write = m_pend[0] & m_wr[0];
            l1i_arb_addr  = m_addr[0];
            l1i_arb_wdata = m_wdata[0];
        end else begin
            l1d_arb_read  = m_pend[1] & m_rd[1];
            l1d_arb_write = m_pend[1] & m_wr[1];
            l1d_arb_addr  = m_addr[1];
            l1d_arb_wdata = m_wdata[1];
        end
    endtask

    task automatic issue(input int who, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [255:0] wdata);
        m_pend[who]  = 1'b1;
        m_rd[who]    = rd;
        m_wr[who]    = wr;
        m_addr[who]  = addr;
        m_wdata[who] = wdata;
        drive(who);
    endtask

    task automatic drop(input int who);
        m_pend[who] = 1'b0;
        drive(who);
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_pend[w]  = 1'b0;
            m_rd[w]    = 1'b0;
            m_wr[w]    = 1'b0;
            m_rdata[w] = '0;
            drive(w);
        end
        m_ddr_addr  = '0;
        m_ddr_wdata = '0;
        m_last      = 1;
        m_starve    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".rd"},    arb_ddr_read,  1'b0);
        check_eq({tag, ".wr"},    arb_ddr_write, 1'b0);
        check_eq({tag, ".iresp"}, arb_l1i_resp,  1'b0);
        check_eq({tag, ".dresp"}, arb_l1d_resp,  1'b0);
        check_eq({tag, ".addr"},  arb_ddr_addr,  m_ddr_addr);
        check_eq({tag, ".wdata"}, arb_ddr_wdata, m_ddr_wdata);
        check_eq({tag, ".irdata"}, arb_l1i_rdata, m_rdata[0]);
        check_eq({tag, ".drdata"}, arb_l1d_rdata, m_rdata[1]);
    endtask

    // Grant the model's chosen owner, hold DDR for lat cycles, then complete.
    task automatic serve(input int lat, input logic [255:0] rdata);
        int o;
        bit tie;
        tie = m_pend[0] && m_pend[1];
        if (!tie) o = m_pend[0] ? 0 : 1;
`ifdef L1ARB_DCACHE_PRIORITY_EN
        else o = (m_starve == 3) ? 0 : 1;
        if (o == 0) m_starve = 0;
        else if (tie) m_starve++;
`else
        else o = 1 - m_last;
`endif
        m_last      = o;
        last_owner  = o;
        m_ddr_addr  = m_addr[o];
        m_ddr_wdata = m_wdata[o];
        tick();
        check_eq("grant.addr",  arb_ddr_addr,  m_addr[o]);
        check_eq("grant.wdata", arb_ddr_wdata, m_wdata[o]);
        check_eq("grant.rd",    arb_ddr_read,  m_rd[o] & ~m_wr[o]);
        check_eq("grant.wr",    arb_ddr_write, m_wr[o]);
        for (int k = 1; k < lat; k++) begin
            tick();
            check_eq("busy.rd",   arb_ddr_read,  m_rd[o] & ~m_wr[o]);
            check_eq("busy.wr",   arb_ddr_write, m_wr[o]);
            check_eq("busy.resp", {arb_l1i_resp, arb_l1d_resp}, 2'b00);
        end
        ddr_arb_resp  = 1'b1;
        ddr_arb_rdata = rdata;
        tick();
        ddr_arb_resp  = 1'b0;
        ddr_arb_rdata = rnd_line();
        m_rdata[o]    = rdata;
        check_eq("done.iresp", arb_l1i_resp, o == 0);
        check_eq("done.dresp", arb_l1d_resp, o == 1);
        check_eq("done.rd",    arb_ddr_read,  1'b0);
        check_eq("done.wr",    arb_ddr_write, 1'b0);
        check_eq("done.irdata", arb_l1i_rdata, m_rdata[0]);
        check_eq("done.drdata", arb_l1d_rdata, m_rdata[1]);
        drop(o);
        tick();
        check_quiet("idle");
    endtask

    // No request pending: a stray DDR response must change nothing.
    task automatic idle_round();
        ddr_arb_resp  = 1'b1;
        ddr_arb_rdata = rnd_line();
        tick();
        ddr_arb_resp  = 1'b0;
        check_quiet("stray");
        tick();
        check_quiet("stray2");
    endtask

    initial begin
        int exp_order[6];
        logic [255:0] a5;
        logic [255:0] wb;
`ifdef L1ARB_DCACHE_PRIORITY_EN
        exp_order = '{1, 1, 1, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        for (int i = 0; i < 32; i++) a5[i*8 +: 8] = 8'hA5;
        for (int i = 0; i < 16; i++) wb[i*16 +: 16] = 16'h1234;
        ddr_arb_resp  = 1'b0;
        ddr_arb_rdata = '0;
        last_owner    = -1;
        do_reset();
        check_quiet("reset");

        // Single icache read with a 5-cycle DDR latency.
        issue(0, 1'b1, 1'b0, 32'h0000_1000, rnd_line());
        serve(5, a5);

        // Simultaneous requests out of reset, then sustained contention.
        do_reset();
        issue(0, 1'b1, 1'b0, 32'h100, rnd_line());
        issue(1, 1'b1, 1'b0, 32'h200, rnd_line());
        for (int t = 0; t < 6; t++) begin
            serve(2, rnd_line());
            check_eq("order", last_owner, exp_order[t]);
            issue(last_owner, 1'b1, 1'b0, $urandom, rnd_line());
        end
        // Let the contention run out.
        while (m_pend[0] || m_pend[1]) serve(1, rnd_line());

        // Dcache writeback with read and write both high.
        issue(1, 1'b1, 1'b1, 32'h300, wb);
        serve(3, rnd_line());

        // Reset two cycles into BUSY, then a late DDR response.
        issue(0, 1'b1, 1'b0, 32'h4000, rnd_line());
        tick();
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        check_quiet("rstbusy");
        ddr_arb_resp  = 1'b1;
        ddr_arb_rdata = rnd_line();
        tick();
        ddr_arb_resp  = 1'b0;
        check_quiet("lateresp");
        tick();
        check_quiet("lateresp2");

        idle_round();

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int w = 0; w < 2; w++) begin
                if (!m_pend[w] && $urandom_range(0, 2) != 0) begin
                    int op;
                    op = $urandom_range(0, 2);
                    issue(w, op != 1, op != 0, $urandom, rnd_line());
                end
            end
            if (m_pend[0] || m_pend[1]) serve($urandom_range(1, 6), rnd_line());
            else idle_round();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_ddr_arbiter.md
Name: l1_ddr_arbiter

Overview:
- Shares the single cacheline-wide DDR port between two L1 cache instances: requester 0 is the instruction cache and requester 1 is the data cache.
- Sits between the DDR-side ports of both caches and the DDR controller.
- Grants one cacheline transaction at a time, registers the granted request onto the DDR port, and routes the response back to its owner.
- Default arbitration is round-robin.

Parameters:
addr_bits, 32, width of rvga_word addresses.
line_bits, 256, width of rvga_cacheline data.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
l1i_arb_addr  in  addr_bits  icache line address
l1i_arb_read  in  1  icache line read request
l1i_arb_write  in  1  icache line write request
l1i_arb_wdata  in  line_bits  icache writeback data
arb_l1i_rdata  out  line_bits  line returned to icache
arb_l1i_resp  out  1  icache transaction-complete pulse
l1d_arb_addr  in  addr_bits  dcache line address
l1d_arb_read  in  1  dcache line read request
l1d_arb_write  in  1  dcache line write request
l1d_arb_wdata  in  line_bits  dcache writeback data
arb_l1d_rdata  out  line_bits  line returned to dcache
arb_l1d_resp  out  1  dcache transaction-complete pulse
arb_ddr_addr  out  addr_bits  DDR address
arb_ddr_read  out  1  DDR read
arb_ddr_write  out  1  DDR write
arb_ddr_wdata  out  line_bits  DDR write data
ddr_arb_rdata  in  line_bits  DDR read data
ddr_arb_resp  in  1  DDR completion

Behaviour:
- Clocking and outputs:
  - One clock, clk. Synchronous, active-high rst.
  - All outputs are registered.
- Reset values:
  - All outputs are 0: addr, wdata, rdata, read, write and resp.
  - State = IDLE.
  - last_grant = 1 (dcache), so the icache wins the first tie.
- Request definition: a requester is pending when its read or write is high. If read and write are both high, the transaction is treated as a write.
- State IDLE:
  - If any requester is pending, select the owner:
    - If only one is pending, it is the owner.
    - If both are pending, the owner is the requester that is not last_grant.
  - On selection, in the next cycle:
    - arb_ddr_addr, arb_ddr_wdata and the read/write op are latched from the owner.
    - last_grant is set to the owner.
    - State goes to BUSY.
  - ddr_arb_resp seen in IDLE is ignored.
- State BUSY:
  - arb_ddr_read/arb_ddr_write are held constant.
  - Requester inputs are not resampled.
  - On ddr_arb_resp:
    - arb_ddr_read and arb_ddr_write are cleared the next cycle.
    - ddr_arb_rdata is captured into the owner's rdata register. It is captured on writes too; the value is don't-care.
    - The owner's resp is asserted for exactly 1 cycle.
    - State goes to DONE.
- State DONE:
  - Lasts 1 cycle; the owner's resp is high during it.
  - Requests are ignored, which gives the owner time to drop read/write.
  - Next state is IDLE.
- Latency and throughput:
  - Request high in IDLE at cycle N → DDR read/write high at N+1.
  - ddr_arb_resp at cycle M → owner resp high at M+1; IDLE at M+2; the earliest next grant is visible at M+3.
  - Maximum throughput is one transaction per DDR latency plus 3 cycles.
- rdata registers:
  - arb_l1i_rdata and arb_l1d_rdata hold their values until the owner's next completion.
  - The non-owner's rdata is unchanged.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D.
- Requester drops its request while BUSY: this is illegal. The arbiter still completes the DDR transaction and still pulses resp.
- rst during BUSY: IDLE next cycle and DDR read/write go low. A late ddr_arb_resp after reset is ignored.
- The resp pulse to the non-owner is never asserted.

Optional Feature:
- Macro: L1ARB_DCACHE_PRIORITY_EN.
- Defined:
  - On a tie, the dcache always wins.
  - A 2-bit starvation counter increments on each dcache-won tie and clears on any icache grant.
  - When the counter reaches 3, the next tie goes to the icache. This bounds the icache wait to 3 transactions.
- Undefined: round-robin as described above, and no counter exists.

Test Plan:
- Single icache read, addr 0x0000_1000, DDR resp 5 cycles after DDR read asserts, rdata 0xA5…A5 → arb_ddr_addr = 0x1000, arb_ddr_read high for 5 cycles, then arb_l1i_resp pulses 1 cycle with rdata 0xA5…A5; arb_l1d_resp stays 0.
- Both requesters read simultaneously out of reset (I 0x100, D 0x200) and are held until resp → DDR sees 0x100 first, then 0x200; arb_l1i_resp precedes arb_l1d_resp.
- Continuous contention, 6 transactions → grant order I, D, I, D, I, D. With L1ARB_DCACHE_PRIORITY_EN: D, D, D, I, D, D.
- Dcache writeback, addr 0x300, wdata 0x1234…, with read and write both high → arb_ddr_write = 1, arb_ddr_read = 0, arb_ddr_wdata matches, arb_l1d_resp pulses once, and arb_l1d_rdata updates.
- rst asserted 2 cycles into BUSY, ddr_arb_resp arrives 1 cycle after reset → all outputs 0, state IDLE, and no resp pulse.
- ddr_arb_resp pulsed while IDLE with no requests → no output change.
